seg7_capture: RTL and testbench

//  Reverse path of the 7-segment display driver. Samples the multiplexed, active-low

---
 rtl/seg7_pkg.sv | 63 ++++++
 rtl/seg7_capture_if.sv | 29 ++
 rtl/seg7_pat2sym.sv | 41 ++++
 rtl/seg7_capture.sv | 120 ++++++++++++
 tb/tb_seg7_capture.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : shared segment patterns, symbol type and encoder.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Active-low patterns, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] code;
    logic       blank;
    logic       err;
  } seg7_sym_t;

  localparam seg7_sym_t SYM_BLANK = '{code: 4'h0, blank: 1'b1, err: 1'b0};
  localparam seg7_sym_t SYM_ERR   = '{code: 4'h0, blank: 1'b0, err: 1'b1};

  function automatic seg7_sym_t seg7_digit(input logic [3:0] code);
    seg7_digit = '{code: code, blank: 1'b0, err: 1'b0};
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    case (code)
      4'h0: seg7_encode = SEG_0;
      4'h1: seg7_encode = SEG_1;
      4'h2: seg7_encode = SEG_2;
      4'h3: seg7_encode = SEG_3;
      4'h4: seg7_encode = SEG_4;
      4'h5: seg7_encode = SEG_5;
      4'h6: seg7_encode = SEG_6;
      4'h7: seg7_encode = SEG_7;
      4'h8: seg7_encode = SEG_8;
      4'h9: seg7_encode = SEG_9;
      4'hA: seg7_encode = SEG_A;
      4'hB: seg7_encode = SEG_B;
      4'hC: seg7_encode = SEG_C;
      4'hD: seg7_encode = SEG_D;
      4'hE: seg7_encode = SEG_E;
      default: seg7_encode = SEG_F;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_capture_if.sv
// ---------------------------------------------------------------------------
// seg7_capture_if : sampled display bus plus readback results.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seg7_capture_if #(
  parameter int NDIG = 4
);
  logic                smpl_en;
  logic [6:0]          nseg;
  logic [NDIG-1:0]     ndigsel;
  logic [4*NDIG-1:0]   dout;
  logic [NDIG-1:0]     blank;
  logic [NDIG-1:0]     derr;
  logic [NDIG-1:0]     upd;
  logic                selerr;

  modport master (
    output smpl_en, nseg, ndigsel,
    input  dout, blank, derr, upd, selerr
  );

  modport slave (
    input  smpl_en, nseg, ndigsel,
    output dout, blank, derr, upd, selerr
  );
endinterface

`default_nettype wire

// File: rtl/seg7_pat2sym.sv
// ---------------------------------------------------------------------------
// seg7_pat2sym : segment pattern -> symbol decode (hex via SEG7CAP_HEX_EN). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pat2sym
  import seg7_pkg::*;
(
  input  logic [6:0] i_nseg,
  output seg7_sym_t  o_sym
);

  always_comb begin
    o_sym = SYM_ERR;
    case (i_nseg)
      SEG_0:     o_sym = seg7_digit(4'h0);
      SEG_1:     o_sym = seg7_digit(4'h1);
      SEG_2:     o_sym = seg7_digit(4'h2);
      SEG_3:     o_sym = seg7_digit(4'h3);
      SEG_4:     o_sym = seg7_digit(4'h4);
      SEG_5:     o_sym = seg7_digit(4'h5);
      SEG_6:     o_sym = seg7_digit(4'h6);
      SEG_7:     o_sym = seg7_digit(4'h7);
      SEG_8:     o_sym = seg7_digit(4'h8);
      SEG_9:     o_sym = seg7_digit(4'h9);
      SEG_BLANK: o_sym = SYM_BLANK;
`ifdef SEG7CAP_HEX_EN
      SEG_A:     o_sym = seg7_digit(4'hA);
      SEG_B:     o_sym = seg7_digit(4'hB);
      SEG_C:     o_sym = seg7_digit(4'hC);
      SEG_D:     o_sym = seg7_digit(4'hD);
      SEG_E:     o_sym = seg7_digit(4'hE);
      SEG_F:     o_sym = seg7_digit(4'hF);
`endif
      default:   o_sym = SYM_ERR;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture : multiplexed 7-seg readback with per-digit stability filter.
// Optional hex decode via SEG7CAP_HEX_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic           clk,
  input  logic           nrst,
  seg7_capture_if.slave  bus
);

  localparam int         IDXW     = $clog2(NDIG);
  localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);

  logic            r_valid;
  logic [6:0]      r_nseg;
  logic [NDIG-1:0] r_ndigsel;

  seg7_sym_t       r_cand [NDIG];
  logic [3:0]      r_cnt  [NDIG];
  seg7_sym_t       r_comm [NDIG];
  logic [NDIG-1:0] r_upd;
  logic            r_selerr;

  logic [3:0]      w_nlow;
  logic [IDXW-1:0] w_idx;
  logic            w_onehot;
  seg7_sym_t       w_sym;
  logic [3:0]      w_cnt_nxt;
  logic            w_take;
  logic            w_commit;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_valid   <= 1'b0;
      r_nseg    <= SEG_BLANK;
      r_ndigsel <= '1;
    end else begin
      r_valid <= bus.smpl_en;
      if (bus.smpl_en) begin
        r_nseg    <= bus.nseg;
        r_ndigsel <= bus.ndigsel;
      end
    end
  end

  always_comb begin
    w_nlow = 4'd0;
    w_idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_ndigsel[i]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = IDXW'(i);
      end
    end
    w_onehot = (w_nlow == 4'd1);
  end

  seg7_pat2sym u_dec (
    .i_nseg (r_nseg),
    .o_sym  (w_sym)
  );

  // Commit only on the exact sample that reaches the threshold, so long runs never recommit
  always_comb begin
    w_take    = r_valid && w_onehot;
    w_cnt_nxt = 4'd1;
    if (w_sym == r_cand[w_idx])
      w_cnt_nxt = (r_cnt[w_idx] == 4'hF) ? 4'hF : r_cnt[w_idx] + 4'd1;
    w_commit  = w_take && (w_cnt_nxt == C_STABLE) && (w_sym != r_comm[w_idx]);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < NDIG; k++) begin
        r_cand[k] <= SYM_BLANK;
        r_cnt[k]  <= 4'd0;
        r_comm[k] <= SYM_BLANK;
      end
      r_upd    <= '0;
      r_selerr <= 1'b0;
    end else begin
      r_upd    <= '0;
      r_selerr <= r_valid && !w_onehot;
      if (w_take) begin
        r_cand[w_idx] <= w_sym;
        r_cnt[w_idx]  <= w_cnt_nxt;
        if (w_commit) begin
          r_comm[w_idx] <= w_sym;
          r_upd[w_idx]  <= 1'b1;
        end
      end
    end
  end

  logic [4*NDIG-1:0] w_dout;
  logic [NDIG-1:0]   w_blank;
  logic [NDIG-1:0]   w_derr;

  for (genvar k = 0; k < NDIG; k++) begin : g_out
    assign w_dout[4*k +: 4] = r_comm[k].code;
    assign w_blank[k]       = r_comm[k].blank;
    assign w_derr[k]        = r_comm[k].err;
  end

  assign bus.dout   = w_dout;
  assign bus.blank  = w_blank;
  assign bus.derr   = w_derr;
  assign bus.upd    = r_upd;
  assign bus.selerr = r_selerr;

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture : scoreboard bench for seg7_capture (STABLE_CNT 3 and 1). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_seg7_capture;

  typedef struct packed {
    logic [3:0]  upd;
    logic        selerr;
    logic [15:0] dout;
    logic [3:0]  blank;
    logic [3:0]  derr;
  } ev_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb0 [$];
  ev_t  got;
  ev_t  want;

  seg7_capture_if #(.NDIG(4)) b0 ();
  seg7_capture_if #(.NDIG(4)) b1 ();

  seg7_capture #(.NDIG(4), .STABLE_CNT(3)) dut0 (.clk(clk), .nrst(nrst), .bus(b0));
  seg7_capture #(.NDIG(4), .STABLE_CNT(1)) dut1 (.clk(clk), .nrst(nrst), .bus(b1));

  always #5 clk = ~clk;

  // Every output event of dut0 must match the next expectation queued by the stimulus
  always @(negedge clk) begin
    if (b0.upd != 4'd0 || b0.selerr) begin
      got = '{upd: b0.upd, selerr: b0.selerr, dout: b0.dout, blank: b0.blank, derr: b0.derr};
      n_cmp++;
      if (sb0.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got upd=%b selerr=%b dout=%h blank=%b derr=%b, required no event",
                 got.upd, got.selerr, got.dout, got.blank, got.derr);
      end else begin
        want = sb0.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL sb_event: got upd=%b selerr=%b dout=%h blank=%b derr=%b, required upd=%b selerr=%b dout=%h blank=%b derr=%b",
                   got.upd, got.selerr, got.dout, got.blank, got.derr,
                   want.upd, want.selerr, want.dout, want.blank, want.derr);
        end
      end
    end
  end

  task automatic push_ev(input logic [3:0] u, input logic s, input logic [15:0] d,
                         input logic [3:0] b, input logic [3:0] e);
    ev_t ev;
    ev = '{upd: u, selerr: s, dout: d, blank: b, derr: e};
    sb0.push_back(ev);
  endtask

  task automatic strobe(input logic [3:0] sel, input logic [6:0] seg);
    @(negedge clk);
    b0.smpl_en = 1'b1;
    b0.ndigsel = sel;
    b0.nseg    = seg;
    @(negedge clk);
    b0.smpl_en = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (b0.dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout: got %h required 0000", b0.dout); end
    n_cmp++; if (b0.blank !== 4'hF) begin n_bad++; $display("FAIL reset_blank: got %b required 1111", b0.blank); end
    n_cmp++; if (b0.derr !== 4'h0) begin n_bad++; $display("FAIL reset_derr: got %b required 0000", b0.derr); end
    n_cmp++; if (b0.upd !== 4'h0 || b0.selerr !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got upd=%b selerr=%b required 0", b0.upd, b0.selerr); end
    n_cmp++; if (b1.blank !== 4'hF) begin n_bad++; $display("FAIL reset_blank1: got %b required 1111", b1.blank); end
    nrst = 1'b1;
  endtask

  task automatic test_single_digit;
    strobe(4'b1110, 7'b0100100);
    strobe(4'b1110, 7'b0100100);
    push_ev(4'b0001, 1'b0, 16'h0002, 4'b1110, 4'b0000);
    strobe(4'b1110, 7'b0100100);
    strobe(4'b1110, 7'b0100100);
    repeat (3) @(negedge clk);
    n_cmp++; if (sb0.size() != 0) begin n_bad++; $display("FAIL single_pending: got %0d pending events required 0", sb0.size()); end
    n_cmp++; if (b0.dout !== 16'h0002) begin n_bad++; $display("FAIL single_dout: got %h required 0002", b0.dout); end
  endtask

  task automatic test_debounce;
    strobe(4'b1101, 7'b0010000);
    strobe(4'b1101, 7'b0010000);
    strobe(4'b1101, 7'b0010010);
    strobe(4'b1101, 7'b0010000);
    strobe(4'b1101, 7'b0010000);
    push_ev(4'b0010, 1'b0, 16'h0092, 4'b1100, 4'b0000);
    strobe(4'b1101, 7'b0010000);
    repeat (3) @(negedge clk);
    n_cmp++; if (sb0.size() != 0) begin n_bad++; $display("FAIL debounce_pending: got %0d pending events required 0", sb0.size()); end
  endtask

  task automatic test_selerr;
    strobe(4'b0111, 7'b1011000);
    strobe(4'b0111, 7'b1011000);
    push_ev(4'b0000, 1'b1, 16'h0092, 4'b1100, 4'b0000);
    strobe(4'b1100, 7'b1011000);
    push_ev(4'b0000, 1'b1, 16'h0092, 4'b1100, 4'b0000);
    strobe(4'b1111, 7'b1011000);
    repeat (3) @(negedge clk);
    n_cmp++; if (b0.dout !== 16'h0092) begin n_bad++; $display("FAIL selerr_dout: got %h required 0092", b0.dout); end
    push_ev(4'b1000, 1'b0, 16'h7092, 4'b0100, 4'b0000);
    strobe(4'b0111, 7'b1011000);
    repeat (3) @(negedge clk);
    n_cmp++; if (sb0.size() != 0) begin n_bad++; $display("FAIL selerr_pending: got %0d pending events required 0", sb0.size()); end
  endtask

  task automatic test_hex;
    strobe(4'b1011, 7'b0001000);
    strobe(4'b1011, 7'b0001000);
`ifdef SEG7CAP_HEX_EN
    push_ev(4'b0100, 1'b0, 16'h7A92, 4'b0000, 4'b0000);
`else
    push_ev(4'b0100, 1'b0, 16'h7092, 4'b0000, 4'b0100);
`endif
    strobe(4'b1011, 7'b0001000);
    repeat (3) @(negedge clk);
    n_cmp++; if (sb0.size() != 0) begin n_bad++; $display("FAIL hex_pending: got %0d pending events required 0", sb0.size()); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] sels    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] pats    [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [3:0] exp_upd [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        b1.smpl_en = 1'b1;
        b1.ndigsel = sels[c];
        b1.nseg    = pats[c];
      end else begin
        b1.smpl_en = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (b1.upd !== exp_upd[c]) begin
        n_bad++;
        $display("FAIL b2b_upd[%0d]: got %b required %b", c, b1.upd, exp_upd[c]);
      end
    end
    n_cmp++; if (b1.dout !== 16'h4321) begin n_bad++; $display("FAIL b2b_dout: got %h required 4321", b1.dout); end
    n_cmp++; if (b1.blank !== 4'h0) begin n_bad++; $display("FAIL b2b_blank: got %b required 0000", b1.blank); end
  endtask

  task automatic test_reset_mid;
    strobe(4'b1110, 7'b0110000);
    strobe(4'b1110, 7'b0110000);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    n_cmp++; if (b0.dout !== 16'h0000) begin n_bad++; $display("FAIL rmid_dout: got %h required 0000", b0.dout); end
    n_cmp++; if (b0.blank !== 4'hF || b0.derr !== 4'h0) begin n_bad++; $display("FAIL rmid_flags: got blank=%b derr=%b required 1111/0000", b0.blank, b0.derr); end
    strobe(4'b1110, 7'b0110000);
    strobe(4'b1110, 7'b0110000);
    push_ev(4'b0001, 1'b0, 16'h0003, 4'b1110, 4'b0000);
    strobe(4'b1110, 7'b0110000);
    repeat (3) @(negedge clk);
    n_cmp++; if (sb0.size() != 0) begin n_bad++; $display("FAIL rmid_pending: got %0d pending events required 0", sb0.size()); end
  endtask

  initial begin
    b0.smpl_en = 1'b0; b0.ndigsel = 4'hF; b0.nseg = 7'h7F;
    b1.smpl_en = 1'b0; b1.ndigsel = 4'hF; b1.nseg = 7'h7F;
    test_reset();
    test_single_digit();
    test_debounce();
    test_selerr();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
